shift_rows_pipe: RTL and testbench

- Parametrised, registered ShiftRows / InvShiftRows engine for the AES/Rijndael datapath.
- Supports block widths of Nb = 4, 6 or 8 columns and a per-transfer direction select (forward for encryption, inverse for decryption).
- Elastic pipeline with valid/ready handshakes on both sides, so it drops between the SubBytes and MixColumns stages of either round pipeline without extra buffering.

---
 rtl/shift_rows_pipe.sv | 119 +++++++++++
 tb/tb_shift_rows_pipe.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_rows_pipe.sv
// Elastic ShiftRows / InvShiftRows pipeline for Rijndael states of NB = 4, 6 or 8 columns.
// Define SHIFT_ROWS_BYPASS_EN to add IN_BYPASS, which lets a state pass through unpermuted.
module shift_rows_pipe #(
    parameter int NB     = 4,
    parameter int STAGES = 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic              IN_INV,
`ifdef SHIFT_ROWS_BYPASS_EN
    input  logic              IN_BYPASS,
`endif
    input  logic [0:32*NB-1]  IN_DATA,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [0:32*NB-1]  OUT_DATA,
    output logic [2:0]        OCCUPANCY
);

    localparam int W    = 32 * NB;
    localparam int LAST = STAGES - 1;

    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
        $error("shift_rows_pipe: NB must be 4, 6 or 8");
    end
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("shift_rows_pipe: STAGES must be in 1..4");
    end

    // Rijndael widens the shift of rows 2 and 3 by one for 256-bit blocks.
    function automatic int row_off(input int r);
        if (NB == 8 && r >= 2) begin
            return r + 1;
        end
        return r;
    endfunction

    logic [0:W-1] perm_data;

    always_comb begin
        perm_data = IN_DATA;
        for (int c = 0; c < NB; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (IN_INV) begin
                    perm_data[8*(4*c+r) +: 8] = IN_DATA[8*(4*((c + NB - row_off(r)) % NB) + r) +: 8];
                end else begin
                    perm_data[8*(4*c+r) +: 8] = IN_DATA[8*(4*((c + row_off(r)) % NB) + r) +: 8];
                end
            end
        end
`ifdef SHIFT_ROWS_BYPASS_EN
        if (IN_BYPASS) begin
            perm_data = IN_DATA;
        end
`endif
    end

    // Handshake: a transfer happens on a rising edge where VALID && READY on that side.
    // take[i] means stage i loads this cycle; take[STAGES] is the downstream sink (OUT_READY),
    // so readiness ripples backwards from the output and never looks at IN_VALID.
    logic [0:W-1]      data_q [STAGES];
    logic [0:W-1]      data_d [STAGES];
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] v_d;
    logic [STAGES:0]   take;
    logic [2:0]        occ_sum;

    always_comb begin
        take         = '0;
        take[STAGES] = OUT_READY;
        for (int i = LAST; i >= 0; i--) begin
            take[i] = !v_q[i] || take[i+1];
        end
    end

    always_comb begin
        v_d    = v_q;
        data_d = data_q;
        if (take[0]) begin
            v_d[0] = IN_VALID;
            if (IN_VALID) begin
                data_d[0] = perm_data;
            end
        end
        for (int i = 1; i < STAGES; i++) begin
            if (take[i]) begin
                v_d[i] = v_q[i-1];
                if (v_q[i-1]) begin
                    data_d[i] = data_q[i-1];
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            v_q    <= '0;
            data_q <= '{default: '0};
        end else begin
            v_q    <= v_d;
            data_q <= data_d;
        end
    end

    always_comb begin
        occ_sum = '0;
        for (int i = 0; i < STAGES; i++) begin
            occ_sum = occ_sum + 3'(v_q[i]);
        end
    end

    assign IN_READY  = take[0];
    assign OUT_VALID = v_q[LAST];
    assign OUT_DATA  = data_q[LAST];
    assign OCCUPANCY = occ_sum;

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Bench for shift_rows_pipe: three instances (NB4/S1, NB8/S2, NB4/S3) with per-instance scoreboards.
module tb_shift_rows_pipe;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // a: NB=4 STAGES=1, b: NB=8 STAGES=2, c: NB=4 STAGES=3
    logic         in_valid_a, in_ready_a, in_inv_a, out_valid_a, out_ready_a;
    logic [0:127] in_data_a, out_data_a;
    logic [2:0]   occupancy_a;
    logic         in_valid_b, in_ready_b, in_inv_b, out_valid_b, out_ready_b;
    logic [0:255] in_data_b, out_data_b;
    logic [2:0]   occupancy_b;
    logic         in_valid_c, in_ready_c, in_inv_c, out_valid_c, out_ready_c;
    logic [0:127] in_data_c, out_data_c;
    logic [2:0]   occupancy_c;
`ifdef SHIFT_ROWS_BYPASS_EN
    logic         in_bypass_a, in_bypass_b, in_bypass_c;
`endif

    shift_rows_pipe #(.NB(4), .STAGES(1)) u_a (
        .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid_a), .IN_READY(in_ready_a), .IN_INV(in_inv_a),
`ifdef SHIFT_ROWS_BYPASS_EN
        .IN_BYPASS(in_bypass_a),
`endif
        .IN_DATA(in_data_a), .OUT_VALID(out_valid_a), .OUT_READY(out_ready_a),
        .OUT_DATA(out_data_a), .OCCUPANCY(occupancy_a)
    );

    shift_rows_pipe #(.NB(8), .STAGES(2)) u_b (
        .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid_b), .IN_READY(in_ready_b), .IN_INV(in_inv_b),
`ifdef SHIFT_ROWS_BYPASS_EN
        .IN_BYPASS(in_bypass_b),
`endif
        .IN_DATA(in_data_b), .OUT_VALID(out_valid_b), .OUT_READY(out_ready_b),
        .OUT_DATA(out_data_b), .OCCUPANCY(occupancy_b)
    );

    shift_rows_pipe #(.NB(4), .STAGES(3)) u_c (
        .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid_c), .IN_READY(in_ready_c), .IN_INV(in_inv_c),
`ifdef SHIFT_ROWS_BYPASS_EN
        .IN_BYPASS(in_bypass_c),
`endif
        .IN_DATA(in_data_c), .OUT_VALID(out_valid_c), .OUT_READY(out_ready_c),
        .OUT_DATA(out_data_c), .OCCUPANCY(occupancy_c)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: moves each source byte to its destination column.
    function automatic logic [0:255] ref_shift(input int nb, input logic [0:255] s, input logic inv);
        logic [0:255] o;
        int offs [4];
        int dst;
        o = '0;
        if (nb == 8) offs = '{0, 1, 3, 4};
        else         offs = '{0, 1, 2, 3};
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < nb; c++) begin
                dst = inv ? (c + offs[r]) % nb : (c - offs[r] + nb) % nb;
                o[8*(4*dst+r) +: 8] = s[8*(4*c+r) +: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [0:127] ref4(input logic [0:127] d, input logic inv);
        logic [0:255] t;
        t = ref_shift(4, {d, 128'h0}, inv);
        return t[0:127];
    endfunction

    function automatic logic [0:127] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Scoreboards
    logic [127:0] exp_q_a[$];
    logic [255:0] exp_q_b[$];
    logic [127:0] exp_q_c[$];
    int           stamp_a[$], stamp_b[$], stamp_c[$];
    logic         lat_chk_a = 1'b0, lat_chk_b = 1'b0, lat_chk_c = 1'b0;
    int           occ_m_c = 0, emitted_c = 0, max_occ_c = 0;
    logic         prev_stall_c = 1'b0, saw_block_c = 1'b0;
    logic [0:127] prev_data_c = '0;
    logic [0:255] last_out_b = '0;

    always @(negedge clk) begin
        if (rst_n && out_valid_a && out_ready_a) begin
            if (exp_q_a.size() == 0) check("a_unexpected_output", 1, 0);
            else begin
                check("a_data", out_data_a, exp_q_a.pop_front());
                if (lat_chk_a) check("a_latency", cyc - stamp_a.pop_front(), 1);
                else void'(stamp_a.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid_b && out_ready_b) begin
            last_out_b <= out_data_b;
            if (exp_q_b.size() == 0) check("b_unexpected_output", 1, 0);
            else begin
                check("b_data", out_data_b, exp_q_b.pop_front());
                if (lat_chk_b) check("b_latency", cyc - stamp_b.pop_front(), 2);
                else void'(stamp_b.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            occ_m_c      <= 0;
            prev_stall_c <= 1'b0;
        end else begin
            check("c_occupancy", occupancy_c, occ_m_c);
            if (prev_stall_c) begin
                check("c_stall_valid", out_valid_c, 1);
                check("c_stall_data", out_data_c, prev_data_c);
            end
            if (out_valid_c && out_ready_c) begin
                emitted_c <= emitted_c + 1;
                if (exp_q_c.size() == 0) check("c_unexpected_output", 1, 0);
                else begin
                    check("c_data", out_data_c, exp_q_c.pop_front());
                    if (lat_chk_c) check("c_latency", cyc - stamp_c.pop_front(), 3);
                    else void'(stamp_c.pop_front());
                end
            end
            occ_m_c      <= occ_m_c + int'(in_valid_c && in_ready_c) - int'(out_valid_c && out_ready_c);
            prev_stall_c <= out_valid_c && !out_ready_c;
            prev_data_c  <= out_data_c;
            if (int'(occupancy_c) > max_occ_c) max_occ_c <= int'(occupancy_c);
            if (in_valid_c && !in_ready_c) saw_block_c <= 1'b1;
        end
    end

    // Drivers: called just after a rising edge; expected value queued when acceptance is seen.
    task automatic send_a(input logic [0:127] d, input logic inv, input logic [0:127] e);
        logic got = 1'b0;
        in_valid_a = 1'b1; in_data_a = d; in_inv_a = inv;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (in_ready_a) begin
                exp_q_a.push_back(e); stamp_a.push_back(cyc); got = 1'b1;
            end
        end
        if (!got) check("a_accept_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid_a = 1'b0;
    endtask

    task automatic send_b(input logic [0:255] d, input logic inv, input logic [0:255] e);
        logic got = 1'b0;
        in_valid_b = 1'b1; in_data_b = d; in_inv_b = inv;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (in_ready_b) begin
                exp_q_b.push_back(e); stamp_b.push_back(cyc); got = 1'b1;
            end
        end
        if (!got) check("b_accept_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid_b = 1'b0;
    endtask

    task automatic send_c(input logic [0:127] d, input logic inv, input logic byp, input logic [0:127] e);
        logic got = 1'b0;
        in_valid_c = 1'b1; in_data_c = d; in_inv_c = inv;
`ifdef SHIFT_ROWS_BYPASS_EN
        in_bypass_c = byp;
`endif
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (in_ready_c) begin
                exp_q_c.push_back(e); stamp_c.push_back(cyc); got = 1'b1;
            end
        end
        if (!got) check("c_accept_timeout", {255'b0, byp}, 256'h1_0000);
        @(posedge clk); #1;
        in_valid_c = 1'b0;
    endtask

    task automatic wait_drain();
        logic empty = 1'b0;
        for (int k = 0; k < 100 && !empty; k++) begin
            @(negedge clk);
            empty = (exp_q_a.size() == 0) && (exp_q_b.size() == 0) && (exp_q_c.size() == 0);
        end
        check("drain", empty, 1);
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [0:127] data;
        logic         inv;
        logic [0:127] exp;
    } vec_t;

    vec_t         vecs [8];
    logic [0:127] seq16;
    logic [0:255] seq32;
    logic [0:127] d;
    logic         inv;
    int           base;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        seq16 = 128'h000102030405060708090A0B0C0D0E0F;
        for (int k = 0; k < 32; k++) seq32[8*k +: 8] = 8'(k);
        vecs[0] = '{seq16, 1'b0, 128'h00050A0F_04090E03_080D0207_0C01060B};
        vecs[1] = '{seq16, 1'b1, 128'h000D0A07_04010E0B_0805020F_0C090603};
        vecs[2] = '{128'h00050A0F_04090E03_080D0207_0C01060B, 1'b1, seq16};
        vecs[3] = '{128'h000D0A07_04010E0B_0805020F_0C090603, 1'b0, seq16};
        for (int i = 4; i < 8; i++) begin
            d = rand128();
            vecs[i] = '{d, 1'(i % 2), ref4(d, 1'(i % 2))};
        end

        in_valid_a = 0; in_inv_a = 0; in_data_a = '0; out_ready_a = 1;
        in_valid_b = 0; in_inv_b = 0; in_data_b = '0; out_ready_b = 1;
        in_valid_c = 0; in_inv_c = 0; in_data_c = '0; out_ready_c = 1;
`ifdef SHIFT_ROWS_BYPASS_EN
        in_bypass_a = 0; in_bypass_b = 0; in_bypass_c = 0;
`endif
        rst_n = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_a_valid", out_valid_a, 0);
        check("rst_a_occ", occupancy_a, 0);
        check("rst_a_data", out_data_a, 0);
        check("rst_b_valid", out_valid_b, 0);
        check("rst_b_data", out_data_b, 0);
        check("rst_c_valid", out_valid_c, 0);
        check("rst_c_occ", occupancy_c, 0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel_a_ready", in_ready_a, 1);
        check("rel_b_ready", in_ready_b, 1);
        check("rel_c_ready", in_ready_c, 1);

        // NB=4, one stage: table vectors back-to-back
        lat_chk_a = 1'b1;
        for (int i = 0; i < 8; i++) send_a(vecs[i].data, vecs[i].inv, vecs[i].exp);
        wait_drain();

        // NB=8, two stages
        lat_chk_b = 1'b1;
        send_b(seq32, 1'b0, ref_shift(8, seq32, 1'b0));
        wait_drain();
        check("b_row2_col0", last_out_b[16 +: 8], 8'h0E);
        check("b_row3_col0", last_out_b[24 +: 8], 8'h13);
        check("b_row1_col0", last_out_b[8 +: 8], 8'h05);
        send_b(seq32, 1'b1, ref_shift(8, seq32, 1'b1));
        for (int i = 0; i < 4; i++) begin
            seq32 = {rand128(), rand128()};
            send_b(seq32, 1'(i % 2), ref_shift(8, seq32, 1'(i % 2)));
        end
        wait_drain();

        // NB=4, three stages: unstalled latency
        lat_chk_c = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d = rand128();
            send_c(d, 1'(i % 2), 1'b0, ref4(d, 1'(i % 2)));
        end
        wait_drain();

        // Back-pressure: OUT_READY low for stream cycles 2..6
        lat_chk_c = 1'b0;
        base = emitted_c;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    d = rand128();
                    inv = 1'($urandom_range(0, 1));
                    send_c(d, inv, 1'b0, ref4(d, inv));
                end
            end
            begin
                repeat (2) begin @(posedge clk); #1; end
                out_ready_c = 1'b0;
                repeat (5) begin @(posedge clk); #1; end
                out_ready_c = 1'b1;
                @(negedge clk);
                check("c_pass_through_ready", in_ready_c, 1);
            end
        join
        wait_drain();
        check("c_max_occupancy", max_occ_c, 3);
        check("c_in_ready_dropped", saw_block_c, 1);
        check("c_stream_count", emitted_c - base, 8);

        // Reset with two states in flight
        out_ready_c = 1'b0;
        for (int i = 0; i < 2; i++) send_c(rand128(), 1'b0, 1'b0, '0);
        @(posedge clk); #1;
        check("c_pre_reset_occ", occupancy_c, 2);
        rst_n = 1'b0;
        #1;
        check("c_reset_valid", out_valid_c, 0);
        check("c_reset_occ", occupancy_c, 0);
        exp_q_c.delete();
        stamp_c.delete();
        @(posedge clk); #3;
        rst_n = 1'b1;
        out_ready_c = 1'b1;
        base = emitted_c;
        check("c_post_reset_ready", in_ready_c, 1);
        @(posedge clk); #1;
        lat_chk_c = 1'b1;
        send_c(seq16, 1'b0, 1'b0, vecs[0].exp);
        wait_drain();
        repeat (5) @(posedge clk);
        #1;
        check("c_post_reset_count", emitted_c - base, 1);

`ifdef SHIFT_ROWS_BYPASS_EN
        send_c(seq16, 1'b0, 1'b1, seq16);
        for (int i = 0; i < 4; i++) begin
            d = rand128();
            send_c(d, 1'b0, 1'(i % 2 == 0), (i % 2 == 0) ? d : ref4(d, 1'b0));
        end
        in_bypass_c = 1'b0;
        wait_drain();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
